// File: rtl/register_file.sv
// 32 x 32-bit integer register file: two asynchronous read ports, one write port.
// x0 is not stored and always reads as zero; address 0 on reg_write means "no write".
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read1,
  input  logic [ADDR_WIDTH-1:0] read2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 is deliberately absent; reads of x0 are forced to zero below.
  logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];

  always_comb begin
    regs_d = regs_q;
    if (reg_write != '0) begin
      regs_d[reg_write] = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write-to-read bypass: reads always show the currently stored value.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read1 != '0) begin
      read_data1 = regs_q[read1];
    end
    if (read2 != '0) begin
      read_data2 = regs_q[read2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg_write;
  logic [31:0] write_data;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .write_data (write_data),
    .read1      (read1),
    .read2      (read2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the same inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    if (rst === 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (reg_write != 5'd0) begin
      model[reg_write] = write_data;
    end
    #1;
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; reg_write = 5'd0; write_data = 32'h0; read1 = 5'd0; read2 = 5'd0;
    #1;

    // Reset then read
    tick();
    rst = 1'b0; read1 = 5'd5; read2 = 5'd31;
    #1;
    check("reset_rd1_x5", read_data1, 32'h0000_0000);
    check("reset_rd2_x31", read_data2, 32'h0000_0000);
    for (int i = 0; i < 32; i++) begin
      read1 = i[4:0];
      #1;
      check("reset_all", read_data1, 32'h0000_0000);
    end

    // Basic write/read
    reg_write = 5'd1; write_data = 32'hABCD_EF01;
    tick();
    reg_write = 5'd0; read1 = 5'd1; read2 = 5'd0;
    #1;
    check("basic_rd1", read_data1, 32'hABCD_EF01);
    check("basic_rd2_x0", read_data2, 32'h0000_0000);

    // x0 immutability, including X on write_data
    reg_write = 5'd0; write_data = 32'hFFFF_FFFF;
    tick();
    read1 = 5'd0;
    #1;
    check("x0_ones", read_data1, 32'h0000_0000);
    write_data = 32'hxxxx_xxxx;
    tick();
    read2 = 5'd0;
    #1;
    check("x0_xdata", read_data2, 32'h0000_0000);
    check("x0_keeps_x1", expect_rd(5'd1), 32'hABCD_EF01);

    // Dual-port independence
    reg_write = 5'd3; write_data = 32'h1111_1111;
    tick();
    reg_write = 5'd31; write_data = 32'h2222_2222;
    tick();
    reg_write = 5'd0; read1 = 5'd3; read2 = 5'd31;
    #1;
    check("dual_rd1_x3", read_data1, 32'h1111_1111);
    check("dual_rd2_x31", read_data2, 32'h2222_2222);
    read1 = 5'd31;
    #1;
    check("same_addr_rd1", read_data1, 32'h2222_2222);
    check("same_addr_rd2", read_data2, 32'h2222_2222);

    // Same-cycle read/write: old value before the edge, new after
    reg_write = 5'd7; write_data = 32'hAAAA_0000;
    tick();
    reg_write = 5'd7; write_data = 32'h5555_FFFF; read1 = 5'd7;
    #1;
    check("rw_before_edge", read_data1, 32'hAAAA_0000);
    tick();
    reg_write = 5'd0;
    #1;
    check("rw_after_edge", read_data1, 32'h5555_FFFF);

    // Last write wins
    reg_write = 5'd9; write_data = 32'h0000_0001;
    tick();
    write_data = 32'h0000_0002;
    tick();
    reg_write = 5'd0; read2 = 5'd9;
    #1;
    check("last_write_wins", read_data2, 32'h0000_0002);

    // Reset priority over a same-cycle write
    rst = 1'b1; reg_write = 5'd4; write_data = 32'h1234_5678;
    tick();
    rst = 1'b0; reg_write = 5'd0; read1 = 5'd4; read2 = 5'd1;
    #1;
    check("rst_prio_x4", read_data1, 32'h0000_0000);
    check("rst_prio_x1", read_data2, 32'h0000_0000);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      reg_write  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      write_data = $urandom;
      read1      = 5'($urandom_range(0, 31));
      read2      = ($urandom_range(0, 3) == 0) ? reg_write : 5'($urandom_range(0, 31));
      #1;
      check("rand_pre_rd1", read_data1, expect_rd(read1));
      check("rand_pre_rd2", read_data2, expect_rd(read2));
      tick();
      check("rand_post_rd1", read_data1, expect_rd(read1));
      check("rand_post_rd2", read_data2, expect_rd(read2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit integer register file for the RV32IM pipeline (x0..x31), used by the decode/ID stage for operand reads and by writeback for results.
- Two combinational read ports, one synchronous write port.
- x0 is hardwired to zero.
- Every clock edge writes the register addressed by reg_write; the caller disables writes by driving reg_write = 0.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index; depth = 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  clock; all state changes occur on its rising edge.
- rst  input  1  reset, synchronous, active-high; clears all registers.
- reg_write  input  ADDR_WIDTH  write address (destination register index); 0 = no write.
- write_data  input  DATA_WIDTH  data written to register[reg_write].
- read1  input  ADDR_WIDTH  read port 1 address.
- read2  input  ADDR_WIDTH  read port 2 address.
- read_data1  output  DATA_WIDTH  contents of register[read1].
- read_data2  output  DATA_WIDTH  contents of register[read2].

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Nothing changes between edges except combinational reads.

Reset:
- On a rising edge with rst=1, all 32 registers become 0.
- rst has priority over any write in the same cycle.
- After reset, every read returns 0x00000000.

Write:
- On a rising edge with rst=0 and reg_write != 0: register[reg_write] <= write_data.
- Write latency is 1 edge; the new value is visible on the read ports immediately after that edge.
- reg_write == 0: no state change. Register 0 is never stored, so a write to x0 is discarded.
- No separate write enable: reg_write is sampled every cycle, so an idle writeback must present address 0.

Read:
- Purely combinational, asynchronous, zero-cycle latency: read_dataN = register[readN].
- readN == 0 always yields 0, regardless of past writes or X on write_data.
- Both ports are independent. read1 == read2 returns the same value on both ports.
- No internal write-to-read bypass: when readN == reg_write in the same cycle, read_dataN shows the old value until the edge, then the new value.

Boundary conditions:
- Index 31 is valid.
- All 5-bit addresses are legal; there is no wrap-around or out-of-range case.
- Consecutive writes to the same register: the last write wins.
- Reset asserted mid-sequence clears everything at that edge, including a write presented in the same cycle.
- Unknown (X) read addresses may produce X outputs; the implementation need not guard against this.

Test Plan:
- Reset then read: rst=1 for one edge, then read1=5, read2=31 -> read_data1=0x00000000 and read_data2=0x00000000.
- Basic write/read:
  - Stimulus: rst=0, reg_write=1, write_data=0xABCDEF01; one edge; then reg_write=0, read1=1, read2=0.
  - Required: read_data1=0xABCDEF01, read_data2=0x00000000.
- x0 immutability: reg_write=0 with write_data=0xFFFFFFFF for one edge, then read1=0 -> read_data1=0x00000000.
- Dual-port independence:
  - Stimulus: write x3=0x11111111, then x31=0x22222222; set read1=3, read2=31.
  - Required: read_data1=0x11111111, read_data2=0x22222222. With read1=read2=31, both outputs = 0x22222222.
- Same-cycle read/write:
  - Stimulus: x7 holds 0xAAAA0000; present reg_write=7, write_data=0x5555FFFF, read1=7.
  - Required: read_data1=0xAAAA0000 before the edge, 0x5555FFFF after it.
- Reset priority: rst=1 with reg_write=4, write_data=0x12345678 for one edge -> read x4 returns 0x00000000; previously written x1 also returns 0.
